// File: rtl/ysyx_23060025_axi_xbar.sv
// rtl/ysyx_23060025_axi_xbar.sv - single-outstanding AXI4 crossbar: core port to SoC bus (s0) and read-only CLINT (s1)
module ysyx_23060025_axi_xbar #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [ADDR_LEN-1:0] CLINT_MASK = 32'hFFFF_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_LEN-1:0]   m_ar_addr,
    input  logic [3:0]            m_ar_id,
    input  logic [7:0]            m_ar_len,
    input  logic [2:0]            m_ar_size,
    input  logic [1:0]            m_ar_burst,
    input  logic                  m_ar_valid,
    output logic                  m_ar_ready,
    output logic [DATA_LEN-1:0]   m_r_data,
    output logic [1:0]            m_r_resp,
    output logic                  m_r_last,
    output logic [3:0]            m_r_id,
    output logic                  m_r_valid,
    input  logic                  m_r_ready,
    input  logic [ADDR_LEN-1:0]   m_aw_addr,
    input  logic [3:0]            m_aw_id,
    input  logic [7:0]            m_aw_len,
    input  logic [2:0]            m_aw_size,
    input  logic [1:0]            m_aw_burst,
    input  logic                  m_aw_valid,
    output logic                  m_aw_ready,
    input  logic [DATA_LEN-1:0]   m_w_data,
    input  logic [DATA_LEN/8-1:0] m_w_strb,
    input  logic                  m_w_last,
    input  logic                  m_w_valid,
    output logic                  m_w_ready,
    output logic [1:0]            m_b_resp,
    output logic [3:0]            m_b_id,
    output logic                  m_b_valid,
    input  logic                  m_b_ready,
    output logic [ADDR_LEN-1:0]   s0_ar_addr,
    output logic [3:0]            s0_ar_id,
    output logic [7:0]            s0_ar_len,
    output logic [2:0]            s0_ar_size,
    output logic [1:0]            s0_ar_burst,
    output logic                  s0_ar_valid,
    input  logic                  s0_ar_ready,
    input  logic [DATA_LEN-1:0]   s0_r_data,
    input  logic [1:0]            s0_r_resp,
    input  logic                  s0_r_last,
    input  logic [3:0]            s0_r_id,
    input  logic                  s0_r_valid,
    output logic                  s0_r_ready,
    output logic [ADDR_LEN-1:0]   s0_aw_addr,
    output logic [3:0]            s0_aw_id,
    output logic [7:0]            s0_aw_len,
    output logic [2:0]            s0_aw_size,
    output logic [1:0]            s0_aw_burst,
    output logic                  s0_aw_valid,
    input  logic                  s0_aw_ready,
    output logic [DATA_LEN-1:0]   s0_w_data,
    output logic [DATA_LEN/8-1:0] s0_w_strb,
    output logic                  s0_w_last,
    output logic                  s0_w_valid,
    input  logic                  s0_w_ready,
    input  logic [1:0]            s0_b_resp,
    input  logic [3:0]            s0_b_id,
    input  logic                  s0_b_valid,
    output logic                  s0_b_ready,
    output logic [ADDR_LEN-1:0]   s1_ar_addr,
    output logic [3:0]            s1_ar_id,
    output logic [7:0]            s1_ar_len,
    output logic [2:0]            s1_ar_size,
    output logic [1:0]            s1_ar_burst,
    output logic                  s1_ar_valid,
    input  logic                  s1_ar_ready,
    input  logic [DATA_LEN-1:0]   s1_r_data,
    input  logic [1:0]            s1_r_resp,
    input  logic                  s1_r_last,
    input  logic [3:0]            s1_r_id,
    input  logic                  s1_r_valid,
    output logic                  s1_r_ready,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, RD_SOC, RD_CLINT, WR_SOC, WR_ERR} state_t;

    state_t     state, state_next;
    logic [3:0] err_id, err_id_next;
    logic       ar_clint, aw_clint, s0_wr_ready;

    assign ar_clint    = (m_ar_addr & CLINT_MASK) == CLINT_BASE;
    assign aw_clint    = (m_aw_addr & CLINT_MASK) == CLINT_BASE;
    assign s0_wr_ready = s0_aw_ready & s0_w_ready;
    assign busy        = state != IDLE;

    // Payloads fan out to both slaves; only the valids/readies select the target.
    assign s0_ar_addr  = m_ar_addr;
    assign s0_ar_id    = m_ar_id;
    assign s0_ar_len   = m_ar_len;
    assign s0_ar_size  = m_ar_size;
    assign s0_ar_burst = m_ar_burst;
    assign s1_ar_addr  = m_ar_addr;
    assign s1_ar_id    = m_ar_id;
    assign s1_ar_len   = m_ar_len;
    assign s1_ar_size  = m_ar_size;
    assign s1_ar_burst = m_ar_burst;
    assign s0_aw_addr  = m_aw_addr;
    assign s0_aw_id    = m_aw_id;
    assign s0_aw_len   = m_aw_len;
    assign s0_aw_size  = m_aw_size;
    assign s0_aw_burst = m_aw_burst;
    assign s0_w_data   = m_w_data;
    assign s0_w_strb   = m_w_strb;
    assign s0_w_last   = m_w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            err_id <= '0;
        end else begin
            state  <= state_next;
            err_id <= err_id_next;
        end
    end

    always_comb begin
        state_next  = state;
        err_id_next = err_id;
        m_ar_ready  = 1'b0;
        s0_ar_valid = 1'b0;
        s1_ar_valid = 1'b0;
        m_aw_ready  = 1'b0;
        m_w_ready   = 1'b0;
        s0_aw_valid = 1'b0;
        s0_w_valid  = 1'b0;
        m_r_data    = '0;
        m_r_resp    = '0;
        m_r_last    = 1'b0;
        m_r_id      = '0;
        m_r_valid   = 1'b0;
        s0_r_ready  = 1'b0;
        s1_r_ready  = 1'b0;
        m_b_resp    = '0;
        m_b_id      = '0;
        m_b_valid   = 1'b0;
        s0_b_ready  = 1'b0;
        // Outputs are held at their reset values for as long as reset is high.
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (m_ar_valid) begin
                        if (ar_clint) begin
                            s1_ar_valid = 1'b1;
                            m_ar_ready  = s1_ar_ready;
                            if (s1_ar_ready) state_next = RD_CLINT;
                        end else begin
                            s0_ar_valid = 1'b1;
                            m_ar_ready  = s0_ar_ready;
                            if (s0_ar_ready) state_next = RD_SOC;
                        end
                    end else if (m_aw_valid && m_w_valid) begin
                        if (aw_clint) begin
                            m_aw_ready  = 1'b1;
                            m_w_ready   = 1'b1;
                            err_id_next = m_aw_id;
                            state_next  = WR_ERR;
                        end else begin
                            s0_aw_valid = 1'b1;
                            s0_w_valid  = 1'b1;
                            m_aw_ready  = s0_wr_ready;
                            m_w_ready   = s0_wr_ready;
                            if (s0_wr_ready) state_next = WR_SOC;
                        end
                    end
                end
                RD_SOC: begin
                    m_r_data   = s0_r_data;
                    m_r_resp   = s0_r_resp;
                    m_r_last   = s0_r_last;
                    m_r_id     = s0_r_id;
                    m_r_valid  = s0_r_valid;
                    s0_r_ready = m_r_ready;
                    if (s0_r_valid && m_r_ready && s0_r_last) state_next = IDLE;
                end
                RD_CLINT: begin
                    m_r_data   = s1_r_data;
                    m_r_resp   = s1_r_resp;
                    m_r_last   = s1_r_last;
                    m_r_id     = s1_r_id;
                    m_r_valid  = s1_r_valid;
                    s1_r_ready = m_r_ready;
                    if (s1_r_valid && m_r_ready && s1_r_last) state_next = IDLE;
                end
                WR_SOC: begin
                    m_b_resp   = s0_b_resp;
                    m_b_id     = s0_b_id;
                    m_b_valid  = s0_b_valid;
                    s0_b_ready = m_b_ready;
                    if (s0_b_valid && m_b_ready) state_next = IDLE;
                end
                WR_ERR: begin
                    m_b_valid = 1'b1;
                    m_b_resp  = 2'b10;
                    m_b_id    = err_id;
                    if (m_b_ready) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060025_axi_xbar.md
# ysyx_23060025_axi_xbar

Single-outstanding AXI4 crossbar between the core's arbitrated memory port and two downstream slaves: the SoC bus (slave 0) and the CLINT (slave 1). It sits directly behind the IFU/LSU arbiter. It decodes each request address, routes one transaction at a time to the selected slave, and steers that slave's response back. Writes to the read-only CLINT are terminated locally with SLVERR.

## Interface
- `ADDR_LEN`, 32, address width.
- `DATA_LEN`, 32, data width.
- `CLINT_BASE`, 32'h0200_0000, CLINT region base.
- `CLINT_MASK`, 32'hFFFF_0000, region match mask. An address hits the CLINT when `(addr & CLINT_MASK) == CLINT_BASE`.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `m_ar_addr/id/len/size/burst`  in  ADDR_LEN/4/8/3/2  upstream read address.
- `m_ar_valid` in 1, `m_ar_ready` out 1  upstream read address handshake.
- `m_r_data/resp/last/id`  out  DATA_LEN/2/1/4  upstream read data.
- `m_r_valid` out 1, `m_r_ready` in 1  upstream read data handshake.
- `m_aw_addr/id/len/size/burst`  in  ADDR_LEN/4/8/3/2  upstream write address.
- `m_aw_valid` in 1, `m_aw_ready` out 1  upstream write address handshake.
- `m_w_data/strb/last`  in  DATA_LEN/4/1  upstream write data.
- `m_w_valid` in 1, `m_w_ready` out 1  upstream write data handshake.
- `m_b_resp/id`  out  2/4  upstream write response.
- `m_b_valid` out 1, `m_b_ready` in 1  upstream write response handshake.
- `s0_*`  mirror of the full `m_*` set with directions reversed; carries SoC traffic.
- `s1_ar_*`, `s1_r_*`  mirror of the read channels only; carries CLINT traffic.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, RD_SOC, RD_CLINT, WR_SOC, WR_ERR.
- **IDLE, read selection.** When `m_ar_valid` is high, decode `m_ar_addr`. Forward AR combinationally to the selected slave: payload, valid, and that slave's ready back to `m_ar_ready`. On an AR handshake, move to RD_SOC or RD_CLINT.
- **IDLE, write selection.** When `m_ar_valid` is low and both `m_aw_valid` and `m_w_valid` are high, decode `m_aw_addr`.
  - SoC target: forward AW and W to s0. `m_aw_ready = m_w_ready = s0_aw_ready & s0_w_ready`. `s0_aw_valid` and `s0_w_valid` are asserted only while both upstream valids are high. On the joint handshake, move to WR_SOC.
  - CLINT target: `m_aw_ready = m_w_ready = 1` for one cycle, then move to WR_ERR.
- **Priority.** Read wins over write when both arrive in the same cycle. The upstream master holds AW/W stable until they are accepted.
- **RD_x.** Route the selected slave's R channel to `m_r_*`. `m_r_ready` goes only to the selected slave. Return to IDLE on the `m_r_valid & m_r_ready & m_r_last` handshake.
- **WR_SOC.** Route s0 B to `m_b_*`. Return to IDLE on the B handshake.
- **WR_ERR.**
  - `m_b_valid = 1`, `m_b_resp = 2'b10`, `m_b_id` = captured AW id.
  - Hold these until `m_b_ready`, then return to IDLE.
- **Non-selected slave isolation.**
  - All valids to a non-selected slave are 0.
  - All readies to a non-selected slave are 0.
  - Responses from a non-selected slave are ignored.
- **Idle outputs.** No AR/AW/W is forwarded outside IDLE. `m_r_valid` and `m_b_valid` are 0 in IDLE.
- **Registered state.** The decode result, the captured id, and the state are registered. All other outputs are combinational from state and inputs.

## Timing
- **Reset.**
  - State is IDLE; `busy` = 0.
  - Every valid/ready output = 0.
  - `m_r_data`, `m_r_resp`, `m_b_resp` = 0.
  - Captured id = 0.
- **Reset mid-transaction.** The transaction is abandoned and the block is in IDLE the next cycle. Downstream slaves are reset by the same reset.
- **Latency.** Routed paths (AR, AW, W, R, B) add zero cycles.
  - Error B is asserted the cycle after the AW/W handshake.
  - A new request can be accepted in the cycle after the response handshake. Back-to-back throughput is one transaction per (slave latency + 1) cycles.
- **Bursts.** Multi-beat reads stay in RD_x until the beat with `last` high. Writes are single-beat only (`len = 0`).

## Test plan
- **SoC read.** AR addr 0x8000_0000, id 1; s0 returns data 0xDEAD_BEEF, resp 0 after 3 cycles -> `m_r_data` = 0xDEAD_BEEF, id 1; `busy` falls the cycle after the R handshake; all s1 valids stay 0.
- **CLINT read.** AR addr 0x0200_BFF8 -> routed to s1 only; `m_r_data` = s1 data; the s0 AR valid never rises.
- **CLINT write.** AW 0x0200_0000, id 2, plus W -> accepted in 1 cycle; next cycle `m_b_valid` = 1, resp 2'b10, id 2; with `m_b_ready` low for 4 cycles, valid is held until ready.
- **Simultaneous read and write.** AR 0x8000_0010 and AW/W 0x8000_0020 in the same cycle -> read forwarded first; the write is forwarded only after the R handshake.
- **Read burst.** AR len 3 to s0 -> 4 beats forwarded; the state leaves RD_SOC only on the beat with `last` high; backpressure on `m_r_ready` stalls s0.
- **Reset mid-transaction.** Reset asserted in WR_SOC before B -> next cycle state is IDLE and all outputs are at their reset values; a subsequent read completes normally.
